uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered 8N1-style UART transmitter; sits downstream of the correlator's main block and drives the serial TX pin.
- Main pushes result bytes into an internal FIFO. The shifter serialises them LSB-first, one bit per uart_clk_pulse, the single-cycle baud tick from the UART clock generator.
- Decouples bursty correlation-result output from the slow serial link.

Parameters:
- DATA_BITS, 8, payload bits per frame.
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clki  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- uart_clk_pulse  input  1  one-clki-cycle baud tick; period >= DATA_BITS+STOP_BITS+2 cycles not required, any spacing >= 1 cycle legal.
- data  input  DATA_BITS  byte to enqueue.
- wr_en  input  1  enqueue request, sampled each cycle.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when wr_en is asserted while full.
- busy  output  1  shifter in a frame (state != IDLE).
- TX  output  1  serial line, idle high.

Behaviour:
- Reset (async assert, sync release): FIFO pointers 0, level 0, empty 1, full 0, overflow 0, state IDLE, busy 0, TX 1 (line idle). Reset mid-frame aborts the frame; TX returns to 1 immediately.
- FIFO write: when wr_en=1 and full=0, data is stored at wr_ptr and wr_ptr increments modulo FIFO_DEPTH. When wr_en=1 and full=1, data is dropped and overflow is set to 1 until reset. full, empty and level are registered and reflect the previous edge.
- A write to a full FIFO is dropped even if a pop occurs in the same cycle. A write and a pop in the same cycle with the FIFO non-full leave level unchanged.
- A write into an empty FIFO is not visible to the shifter until the following cycle.
- Pointers wrap modulo FIFO_DEPTH. level is derived from the count register, never from pointer difference alone.
- FSM states: IDLE, START, DATA, STOP. All transitions occur only on cycles with uart_clk_pulse=1; TX is registered.
- IDLE: on a pulse with empty=0, pop the head into shift register sh, set TX<=0, bit_cnt<=0 and go to START. On a pulse with empty=1, remain in IDLE with TX=1.
- START: on a pulse, TX<=sh[0], shift sh right, go to DATA.
- DATA: on each pulse, bit_cnt increments. While bit_cnt<DATA_BITS-1, drive the next bit. When bit_cnt=DATA_BITS-1, set TX<=1, stop_cnt<=0 and go to STOP.
- STOP: on a pulse, if stop_cnt<STOP_BITS-1, increment stop_cnt. Otherwise the frame ends:
  - if empty=0, pop, TX<=0 and go to START (back-to-back frames with no idle bit);
  - else go to IDLE with TX=1.
- Frame length is exactly 1+DATA_BITS+STOP_BITS baud periods. Each bit lasts from one pulse to the next pulse.
- Latency: first start-bit edge occurs on the first uart_clk_pulse at least one cycle after the write; TX changes the cycle after that pulse.
- Pops happen only in IDLE->START or STOP->START transitions, so there is at most one pop per pulse.
- uart_clk_pulse held high continuously is legal: one bit per cycle (used for fast simulation).

Test Plan:
- Single byte: reset, write 0xA5, pulse every 16 cycles -> TX sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit 16 cycles wide; then TX stays 1, busy 0, empty 1.
- Back-to-back: write 0x00 then 0xFF, continuous pulse -> TX 0,0,0,0,0,0,0,0,0,1,0,1,1,1,1,1,1,1,1,1,1. No idle bit between the frames; level goes 2->1->0.
- Fill/overflow: with uart_clk_pulse=0, write 17 bytes 0x00..0x10 -> full=1 after the 16th; the 17th is dropped; overflow=1; level=16. Then enable pulses -> bytes 0x00..0x0F are transmitted in order, and 0x10 never appears.
- Simultaneous write/pop: level=1, write lands on the same cycle as the IDLE->START pop -> level stays 1, and the written byte is transmitted next, back-to-back.
- Reset mid-frame: assert rst during DATA bit 3 of 0x3C -> TX=1, busy=0, level=0, overflow=0 immediately. After release, write 0x81 -> a clean frame 0,1,0,0,0,0,0,0,1,1.
- STOP_BITS=2: write 0x55 -> TX 0,1,0,1,0,1,0,1,0,1,1 (11 baud periods).

Source files
------------

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Buffered 8N1-style UART transmitter. Result bytes are pushed into a small
// FIFO at system-clock rate; a frame shifter drains the FIFO and serialises
// each byte LSB-first onto TX, advancing one bit per uart_clk_pulse. Frames
// are sent back-to-back while the FIFO has data, so a burst of results leaves
// the link without idle gaps.
//
// Parameters
//   DATA_BITS   payload bits per frame
//   FIFO_DEPTH  FIFO entries (power of two, >= 2)
//   STOP_BITS   stop bits per frame (1 or 2)
//
// Ports
//   clki            system clock, all logic on the rising edge
//   rst             asynchronous active-high reset
//   uart_clk_pulse  single-cycle baud tick
//   data            byte to enqueue
//   wr_en           enqueue request, sampled every cycle
//   full            FIFO holds FIFO_DEPTH entries (registered)
//   empty           FIFO holds 0 entries (registered)
//   level           FIFO occupancy (registered)
//   overflow        sticky flag: a write was attempted while full
//   busy            shifter is inside a frame
//   TX              serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clki,
  input  logic                          rst,
  input  logic                          uart_clk_pulse,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          wr_en,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          TX
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int CNT_W  = $clog2(DATA_BITS + 1);
  localparam int STOP_W = 2;

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q,  count_d;
  logic             full_q,   full_d;
  logic             empty_q,  empty_d;
  logic             overflow_q, overflow_d;

  logic             push;
  logic             pop;
  logic [DATA_BITS-1:0] head;

  // ---------------------------------------------------------------------------
  // Shifter state
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [STOP_W-1:0]    stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;

  // A write is accepted only against the registered full flag, so a write
  // to a full FIFO is dropped even when the shifter pops in the same cycle.
  assign push = wr_en & ~full_q;

  // Head of queue read straight from the array; it is only consumed when
  // empty_q is low, so a same-cycle write into an empty FIFO never reaches
  // the shifter before the following cycle.
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_en & full_q);

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Occupancy lives in its own counter; pointer difference alone cannot
    // tell full from empty once the pointers wrap.
    unique case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == DEPTH_LVL);
    empty_d = (count_d == '0);
  end

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clki) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame shifter: every transition is qualified by the baud tick, and TX is
  // a flop so the line changes exactly one cycle after the tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    pop        = 1'b0;

    if (uart_clk_pulse) begin
      unique case (state_q)
        IDLE: begin
          if (!empty_q) begin
            pop       = 1'b1;
            sh_d      = head;
            bit_cnt_d = '0;
            tx_d      = 1'b0;
            state_d   = START;
          end else begin
            tx_d = 1'b1;
          end
        end

        START: begin
          // End of the start bit: present bit 0 and line up bit 1.
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
          state_d = DATA;
        end

        DATA: begin
          if (bit_cnt_q < LAST_BIT) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            tx_d      = sh_q[0];
            sh_d      = sh_q >> 1;
          end else begin
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            tx_d       = 1'b1;
            stop_cnt_d = '0;
            state_d    = STOP;
          end
        end

        STOP: begin
          if (stop_cnt_q < LAST_STOP) begin
            stop_cnt_d = stop_cnt_q + STOP_W'(1);
          end else if (!empty_q) begin
            // Next byte already waiting: go straight into its start bit so
            // consecutive frames have no idle bit between them.
            pop       = 1'b1;
            sh_d      = head;
            bit_cnt_d = '0;
            tx_d      = 1'b0;
            state_d   = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end

        default: begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = count_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE);
  assign TX       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo. A queue-based model predicts the FIFO
// occupancy and the serial frame bit by bit; every cycle the DUT outputs are
// compared against it. TX values sampled after each baud tick are also
// logged and compared with hand-written bit sequences. A second instance with
// two stop bits is checked against a literal sequence only.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int NB    = 10;   // 1 start + 8 data + 1 stop

  logic clki = 1'b0;
  always #5 clki = ~clki;

  logic       rst = 1'b1;
  logic       uart_clk_pulse = 1'b0;
  logic [7:0] data = 8'h00;
  logic       wr_en = 1'b0;
  logic       wr_en2 = 1'b0;

  logic       full, empty, overflow, busy, tx;
  logic [4:0] level;
  logic       full2, empty2, overflow2, busy2, tx2;
  logic [4:0] level2;

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
    .clki(clki), .rst(rst), .uart_clk_pulse(uart_clk_pulse), .data(data),
    .wr_en(wr_en), .full(full), .empty(empty), .level(level),
    .overflow(overflow), .busy(busy), .TX(tx)
  );

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
    .clki(clki), .rst(rst), .uart_clk_pulse(uart_clk_pulse), .data(data),
    .wr_en(wr_en2), .full(full2), .empty(empty2), .level(level2),
    .overflow(overflow2), .busy(busy2), .TX(tx2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned   mq[$];
  logic           m_ovf, m_inframe, m_tx;
  logic [NB-1:0]  m_frame;
  int             m_idx;

  function automatic void model_reset();
    mq.delete();
    m_ovf = 1'b0; m_inframe = 1'b0; m_tx = 1'b1; m_idx = 0; m_frame = '1;
  endfunction

  function automatic void start_frame();
    byte unsigned b;
    b = mq.pop_front();
    m_frame   = {1'b1, b, 1'b0};   // index 0 = start bit, 1..8 = data LSB first, 9 = stop
    m_idx     = 0;
    m_tx      = 1'b0;
    m_inframe = 1'b1;
  endfunction

  // Advance the model across one rising edge with the given inputs.
  function automatic void model_step(input logic p, input logic we, input logic [7:0] d);
    int   sz;
    logic was_empty, was_full;
    sz = mq.size();
    was_empty = (sz == 0);
    was_full  = (sz == DEPTH);
    if (p) begin
      if (!m_inframe) begin
        if (!was_empty) start_frame();
      end else begin
        m_idx++;
        if (m_idx < NB) m_tx = m_frame[m_idx];
        else if (!was_empty) start_frame();
        else begin
          m_inframe = 1'b0;
          m_tx = 1'b1;
        end
      end
    end
    if (we) begin
      if (was_full) m_ovf = 1'b1;
      else mq.push_back(d);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  int   period = 0;
  int   pcnt = 0;
  logic prev_pulse = 1'b0;
  logic log_en = 1'b0;
  logic txlog[$];
  logic txlog2[$];

  // One clock cycle: compare at the falling edge, log the post-tick TX,
  // then drive inputs for the next rising edge and advance the model.
  task automatic cyc(input logic we, input logic [7:0] d, input logic we2);
    logic p;
    @(negedge clki);
    if (!rst) begin
      check("tx",       tx,       m_tx);
      check("busy",     busy,     m_inframe);
      check("level",    level,    mq.size());
      check("empty",    empty,    mq.size() == 0);
      check("full",     full,     mq.size() == DEPTH);
      check("overflow", overflow, m_ovf);
    end
    if (log_en && prev_pulse) begin
      txlog.push_back(tx);
      txlog2.push_back(tx2);
    end
    p = (period != 0) && (pcnt == 0);
    if (period != 0) pcnt = (pcnt + 1) % period;
    uart_clk_pulse = p;
    wr_en  = we;
    wr_en2 = we2;
    data   = d;
    if (rst) model_reset();
    else model_step(p, we, d);
    prev_pulse = p & ~rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic start_log(input int per);
    txlog.delete();
    txlog2.delete();
    log_en = 1'b1;
    period = per;
    pcnt   = 0;
  endtask

  task automatic do_reset();
    period = 0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic check_seq(input string name, input logic q[$], input int n, input logic [255:0] exp);
    logic [255:0] act;
    act = '0;
    foreach (q[i]) act = (act << 1) | 256'(q[i]);
    check({name, "_len"}, q.size(), n);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s_bits: got %h, expected %h", name, act, exp);
    end
    $display("txn %s: %0d bits sampled", name, q.size());
  endtask

  // ---------------- directed tests ----------------
  initial begin : main
    logic [255:0] exp;
    model_reset();

    // Reset state
    do_reset();
    check("rst_tx", tx, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_level", level, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);

    // 1) Single byte 0xA5, tick every 16 cycles
    cyc(1'b1, 8'hA5, 1'b0);
    idle(1);
    start_log(16);
    idle(11 * 16 + 1);
    check_seq("single_a5", txlog, 11, 256'(11'b01010010111));
    check("single_busy", busy, 1'b0);
    check("single_empty", empty, 1'b1);
    check("single_tx", tx, 1'b1);

    // 2) Back-to-back 0x00, 0xFF with continuous tick
    do_reset();
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    idle(1);
    check("b2b_level2", level, 5'd2);
    start_log(1);
    idle(2);
    check("b2b_level1", level, 5'd1);
    idle(20);
    check_seq("b2b", txlog, 21, 256'(21'b000000000_1_0_11111111_1_1));
    check("b2b_level0", level, 5'd0);

    // 3) Fill and overflow
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 16) check("fill_full16", full, 1'b1);
    end
    idle(1);
    check("fill_full", full, 1'b1);
    check("fill_level", level, 5'd16);
    check("fill_ovf", overflow, 1'b1);
    start_log(1);
    idle(171);
    exp = '0;
    for (int b = 0; b < 16; b++) begin
      exp = exp << 1;
      for (int k = 0; k < 8; k++) exp = (exp << 1) | 256'((b >> k) & 1);
      exp = (exp << 1) | 256'(1);
    end
    for (int k = 0; k < 10; k++) exp = (exp << 1) | 256'(1);
    check_seq("fill_drain", txlog, 170, exp);
    check("fill_empty", empty, 1'b1);

    // 4) Write lands on the IDLE->START pop
    period = 0;
    log_en = 1'b0;
    cyc(1'b1, 8'h96, 1'b0);
    start_log(1);
    cyc(1'b1, 8'h0F, 1'b0);
    idle(1);
    check("simul_level", level, 5'd1);
    idle(20);
    check_seq("simul", txlog, 21, 256'(21'b0_01101001_1_0_11110000_1_1));
    check("simul_ovf_sticky", overflow, 1'b1);

    // 5) Reset in the middle of DATA bit 3 of 0x3C
    period = 0;
    log_en = 1'b0;
    cyc(1'b1, 8'h3C, 1'b0);
    cyc(1'b1, 8'h77, 1'b0);
    period = 1;
    pcnt = 0;
    idle(6);
    check("mid_busy", busy, 1'b1);
    check("mid_bit3", tx, 1'b1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("arst_tx", tx, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_level", level, 5'd0);
    check("arst_ovf", overflow, 1'b0);
    period = 0;
    idle(2);
    rst = 1'b0;
    idle(1);
    cyc(1'b1, 8'h81, 1'b0);
    idle(1);
    start_log(1);
    idle(12);
    check_seq("after_rst_81", txlog, 11, 256'(11'b0_10000001_1_1));

    // 6) Two stop bits on the second instance
    period = 0;
    log_en = 1'b0;
    cyc(1'b0, 8'h55, 1'b1);
    idle(1);
    start_log(1);
    idle(12);
    check("stop2_busy_11", busy2, 1'b1);
    idle(1);
    check("stop2_busy_12", busy2, 1'b0);
    check_seq("stop2_55", txlog2, 12, 256'(12'b0_10101010_1_1_1));
    check("stop2_empty", empty2, 1'b1);
    check("stop2_full", full2, 1'b0);
    check("stop2_level", level2, 5'd0);
    check("stop2_ovf", overflow2, 1'b0);
    check("stop2_tx", tx2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
